detector_sequencer: RTL
=======================

DETECTOR_SEQUENCER -- requirements
Module: detector_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: request to run one pattern; sampled only in IDLE or DONE.
REQ-004 SHALL have port pattern, input, 8 bits: serial stimulus, captured on accepted start.
REQ-005 SHALL have port len, input, 4 bits: bit count to drive, captured on accepted start; 0 and values above 8 treated as 8.
REQ-006 SHALL have port w, output, 1 bit: serial bit to the detector FSM.
REQ-007 SHALL have port det_reset, output, 1 bit: clears the detector FSM state.
REQ-008 SHALL have port z, input, 1 bit: Moore output of the detector FSM.
REQ-009 SHALL have port busy, output, 1 bit: high in LOAD, RUN and DRAIN.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when a run completes.
REQ-011 SHALL have port hits, output, 4 bits: number of z=1 samples in the last run.
REQ-012 SHALL have port z_hist, output, 8 bits: captured z samples (see Configuration).

Function
REQ-013 SHALL implement states IDLE, LOAD, RUN, DRAIN, DONE, binary-encoded in 3 bits.
REQ-014 SHALL go IDLE->LOAD on start=1, capture pattern and effective len, and clear hits and z_hist.
REQ-015 SHALL assert det_reset for exactly the one LOAD cycle, then enter RUN; w=0 in LOAD.
REQ-016 SHALL drive w=pattern[7-k] in RUN cycle k, k=0..len-1 (MSB first), one bit per cycle.
REQ-017 SHALL sample z in RUN cycles 1..len-1 and in the single DRAIN cycle, giving exactly len samples, with sample i reflecting the detector state after bit i.
REQ-018 SHALL increment hits by 1 on each z=1 sample; max value 8, no wrap.
REQ-019 SHALL go RUN->DRAIN after cycle len-1, DRAIN->DONE, and DONE->IDLE, with done=1 only in DONE.
REQ-020 SHALL go DONE->LOAD on start=1 in DONE, with back-to-back runs adding no idle cycle.
REQ-021 SHALL ignore start while busy=1; pattern and len changes during a run have no effect.
REQ-022 SHALL hold hits and z_hist stable from DONE until the next accepted start.
REQ-023 SHALL drive w=0 in IDLE, DRAIN and DONE.

Reset
REQ-024 SHALL on reset=1 enter IDLE, with w=0, busy=0, done=0, hits=0 and z_hist=0 on the next edge.
REQ-025 SHALL drive det_reset=1 combinationally whenever reset=1, in addition to LOAD.
REQ-026 SHALL on reset during RUN or DRAIN abort the run with no done pulse; hits of the partial run are discarded.
REQ-027 SHALL give reset priority over start in the same cycle.

Configuration
REQ-028 SHALL, with SEQ_ZHIST_EN defined, shift each z sample into z_hist[0] (older samples toward bit 7) and reset it to 0 on run start.
REQ-029 SHALL, with SEQ_ZHIST_EN undefined, tie z_hist to 8'h00 and remove its register.

Structure
REQ-030 SHALL keep state encodings (IDLE=0, LOAD=1, RUN=2, DRAIN=3, DONE=4), PAT_W=8, LEN_W=4 and HIT_W=4 in a shared package, seq_pkg.
REQ-031 SHALL implement the sample counter and hit counter as one sub-module, seq_counter (bit index, terminal flag, hit increment, clear).

Verification
REQ-032 SHALL check that z tied 1, pattern=8'hA5, len=8: w sequence 1,0,1,0,0,1,0,1; done after 11 cycles from start (LOAD+8 RUN+DRAIN+DONE); hits=8; z_hist=8'hFF.
REQ-033 SHALL check that z tied 0, len=0: 8 bits are driven; hits=0; done pulses once.
REQ-034 SHALL check that with z=1 only in the DRAIN cycle and len=3: hits=1, z_hist=8'h01 (with SEQ_ZHIST_EN), and z_hist=8'h00 without it.
REQ-035 SHALL check that start is held high through a run: the next LOAD follows DONE directly, and det_reset pulses once per run.
REQ-036 SHALL check that reset asserted in RUN cycle 3: IDLE next cycle, w=0, busy=0, hits=0, and no done pulse.
REQ-037 SHALL check that a start pulse while busy is ignored and that pattern changed mid-run does not change w.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the detector sequencer: widths, state encoding
// and the effective-length helper.
// Ports: none (package).
package seq_pkg;

    localparam int PAT_W = 8;
    localparam int LEN_W = 4;
    localparam int HIT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_e;

    // A zero length or anything beyond the pattern width runs all bits.
    function automatic logic [LEN_W-1:0] eff_len(
        input logic [LEN_W-1:0] len_in
    );
        if (len_in == '0 || len_in > LEN_W'(PAT_W)) begin
            return LEN_W'(PAT_W);
        end
        return len_in;
    endfunction

endpackage

// File: rtl/seq_counter.sv
// Bit-index and hit counter for the detector sequencer.
// Ports: clk, reset (sync, active-high); i_clear restarts both counters;
//   i_advance steps the bit index; i_sample/i_z count z=1 samples;
//   i_len effective length; o_idx bit index; o_last index is len-1;
//   o_hits saturating hit count.
module seq_counter
    import seq_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_advance,
    input  logic             i_sample,
    input  logic             i_z,
    input  logic [LEN_W-1:0] i_len,
    output logic [LEN_W-1:0] o_idx,
    output logic             o_last,
    output logic [HIT_W-1:0] o_hits
);

    logic [LEN_W-1:0] r_idx;
    logic [HIT_W-1:0] r_hits;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_idx <= '0;
        end else if (i_advance) begin
            r_idx <= r_idx + LEN_W'(1);
        end
    end

    // A run never yields more than PAT_W samples; the cap is a guard.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_hits <= '0;
        end else if (i_sample && i_z &&
                     r_hits < HIT_W'(PAT_W)) begin
            r_hits <= r_hits + HIT_W'(1);
        end
    end

    assign o_idx  = r_idx;
    assign o_last = (r_idx == i_len - LEN_W'(1));
    assign o_hits = r_hits;

endmodule

// File: rtl/detector_sequencer.sv
// Drives a serial pattern into an external Moore detector and counts
// the z=1 samples. Optional z history register: SEQ_ZHIST_EN.
// Ports: clk, reset (sync, active-high); start, pattern, len request a
//   run; w serial bit and det_reset to the detector; z detector output;
//   busy, done status; hits count; z_hist sample history.
module detector_sequencer
    import seq_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    output logic             w,
    output logic             det_reset,
    input  logic             z,
    output logic             busy,
    output logic             done,
    output logic [HIT_W-1:0] hits,
    output logic [PAT_W-1:0] z_hist
);

    seq_state_e       r_state;
    seq_state_e       w_next;
    logic [PAT_W-1:0] r_pat;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] w_idx;
    logic             w_last;
    logic             w_accept;
    logic             w_load;
    logic             w_run;
    logic             w_drain;
    logic             w_sample;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_load   = 1'b0;
        w_run    = 1'b0;
        w_drain  = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next   = ST_LOAD;
                    w_accept = 1'b1;
                end
            end
            ST_LOAD: begin
                busy   = 1'b1;
                w_load = 1'b1;
                w_next = ST_RUN;
            end
            ST_RUN: begin
                busy  = 1'b1;
                w_run = 1'b1;
                if (w_last) begin
                    w_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy    = 1'b1;
                w_drain = 1'b1;
                w_next  = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_next   = ST_LOAD;
                    w_accept = 1'b1;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Pattern is shifted left so the current bit is always the MSB.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pat <= '0;
            r_len <= LEN_W'(PAT_W);
        end else if (w_accept) begin
            r_pat <= pattern;
            r_len <= eff_len(len);
        end else if (w_run) begin
            r_pat <= {r_pat[PAT_W-2:0], 1'b0};
        end
    end

    // z in RUN cycle k reflects bit k-1; the DRAIN cycle sees the
    // last bit, so cycle 0 of RUN is skipped.
    assign w_sample = (w_run && w_idx != '0) || w_drain;

    seq_counter u_counter (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_accept),
        .i_advance (w_run),
        .i_sample  (w_sample),
        .i_z       (z),
        .i_len     (r_len),
        .o_idx     (w_idx),
        .o_last    (w_last),
        .o_hits    (hits)
    );

`ifdef SEQ_ZHIST_EN
    logic [PAT_W-1:0] r_zhist;

    always_ff @(posedge clk) begin
        if (reset || w_accept) begin
            r_zhist <= '0;
        end else if (w_sample) begin
            r_zhist <= {r_zhist[PAT_W-2:0], z};
        end
    end

    assign z_hist = r_zhist;
`else
    assign z_hist = '0;
`endif

    assign w         = w_run & r_pat[PAT_W-1];
    assign det_reset = reset | w_load;

endmodule
